// File: rtl/calc_pkg.sv
// Shared types and default limits for the calculator execution unit.
package calc_pkg;

  typedef enum logic [1:0] {
    OP_STORE  = 2'd0,
    OP_SHOW   = 2'd1,
    OP_UPDATE = 2'd2,
    OP_CLEAR  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int unsigned MAX_VAL_DEF    = 99999;
  localparam int unsigned MUL_MAX_IN_DEF = 99;

endpackage

// File: rtl/calc_seq_mul.sv
// Shift-add multiplier: one multiplier bit per cycle, IN_W cycles after start.
// done and product are valid together during the last iteration cycle.
module calc_seq_mul #(
  parameter int IN_W  = 14,
  parameter int ACC_W = 17
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ACC_W-1:0]      a,
  input  logic [IN_W-1:0]       b,
  output logic                  done,
  output logic [IN_W+ACC_W-1:0] product
);
  import calc_pkg::*;

  localparam int PW = IN_W + ACC_W;
  localparam int CW = $clog2(IN_W + 1);

  logic [PW-1:0]   acc;
  logic [PW-1:0]   mcand;
  logic [IN_W-1:0] mplier;
  logic [CW-1:0]   cnt;
  logic            run;

  // product is the accumulator after the current step, so the final sum
  // is available in the same cycle as done
  always_comb begin
    product = acc + (mplier[0] ? mcand : '0);
    done    = run && (cnt == CW'(IN_W - 1));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      run    <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (start) begin
      run    <= 1'b1;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= PW'(a);
      mplier <= b;
    end else if (run) begin
      acc    <= product;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (done) run <= 1'b0;
    end
  end

endmodule

// File: rtl/calc_exec_unit.sv
// Calculator execution stage: running total/temp, multi-cycle multiply, overflow.
// Optional build macro CALC_SATURATE_EN clamps overflowing results to MAX_VAL.
module calc_exec_unit
  import calc_pkg::*;
#(
  parameter int          IN_W       = 14,
  parameter int          ACC_W      = 17,
  parameter int unsigned MAX_VAL    = MAX_VAL_DEF,
  parameter int unsigned MUL_MAX_IN = MUL_MAX_IN_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [IN_W-1:0]  in_num,
  input  logic             err_in,
  output logic             out_valid,
  output logic [ACC_W-1:0] out_num,
  output logic             err_out,
  output logic             busy
);

  localparam int PW = IN_W + ACC_W;
  localparam logic [ACC_W-1:0] MAX_V   = ACC_W'(MAX_VAL);
  localparam logic [ACC_W:0]   MAX_SUM = (ACC_W+1)'(MAX_VAL);
  localparam logic [PW-1:0]    MAX_P   = PW'(MAX_VAL);
  localparam logic [IN_W-1:0]  MUL_LIM = IN_W'(MUL_MAX_IN);
`ifdef CALC_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  state_e           state, state_nxt;
  op_e              opc;
  logic [ACC_W-1:0] total, temp;
  logic             overflow;
  logic [ACC_W:0]   sum;
  logic             add_ovf, mul_legal, mul_ovf, accept, mul_start, mul_done;
  logic [PW-1:0]    product;

  // Value written to the affected register (and reported) on overflow
  function automatic logic [ACC_W-1:0] on_ovf(input logic [ACC_W-1:0] kept);
    return SAT ? MAX_V : kept;
  endfunction

  always_comb begin
    opc       = op_e'(op);
    accept    = in_valid && in_ready;
    sum       = {1'b0, total} + {1'b0, temp};
    add_ovf   = sum > MAX_SUM;
    mul_legal = in_num <= MUL_LIM;
    mul_ovf   = product > MAX_P;
    mul_start = accept && (opc == OP_UPDATE) && mul_legal;
    err_out   = err_in | overflow;
  end

  calc_seq_mul #(.IN_W(IN_W), .ACC_W(ACC_W)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .a       (temp),
    .b       (in_num),
    .done    (mul_done),
    .product (product)
  );

  always_ff @(posedge clk) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = mul_start ? ST_MUL : ST_DONE;
      ST_MUL:  if (mul_done) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = reset && (state == ST_IDLE);
    busy      = (state == ST_MUL);
    out_valid = (state == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      total    <= '0;
      temp     <= '0;
      overflow <= 1'b0;
      out_num  <= '0;
    end else if (accept) begin
      case (opc)
        OP_STORE, OP_SHOW: begin
          if (add_ovf) begin
            overflow <= 1'b1;
            total    <= on_ovf(total);
            out_num  <= on_ovf(total);
          end else begin
            total    <= sum[ACC_W-1:0];
            out_num  <= sum[ACC_W-1:0];
          end
          if (opc == OP_STORE) temp <= ACC_W'(in_num);
          else                 temp <= (add_ovf && !SAT) ? temp : '0;
        end
        OP_UPDATE: begin
          // legal operands are finished when the multiplier reports done
          if (!mul_legal) begin
            overflow <= 1'b1;
            temp     <= on_ovf(temp);
            out_num  <= on_ovf(temp);
          end
        end
        default: begin
          total    <= '0;
          temp     <= '0;
          overflow <= 1'b0;
          out_num  <= '0;
        end
      endcase
    end else if (mul_done) begin
      if (mul_ovf) begin
        overflow <= 1'b1;
        temp     <= on_ovf(temp);
        out_num  <= on_ovf(temp);
      end else begin
        temp     <= product[ACC_W-1:0];
        out_num  <= product[ACC_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_calc_exec_unit.sv
// Bench for calc_exec_unit: directed vector table, hand corner sequences, random vs model.
module tb_calc_exec_unit;
  import calc_pkg::*;

  localparam int IN_W  = 14;
  localparam int ACC_W = 17;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             in_valid = 1'b0;
  logic [1:0]       op = 2'd0;
  logic [IN_W-1:0]  in_num = '0;
  logic             err_in = 1'b0;
  logic             in_ready, out_valid, err_out, busy;
  logic [ACC_W-1:0] out_num;

  int n_pass  = 0;
  int n_total = 0;

  longint m_total, m_temp;
  bit     m_ovf;

  typedef struct {
    logic [1:0] op;
    int         num;
    int         res;
    bit         err;
    int         lat;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  calc_exec_unit #(.IN_W(IN_W), .ACC_W(ACC_W), .MAX_VAL(99999), .MUL_MAX_IN(99)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .in_num    (in_num),
    .err_in    (err_in),
    .out_valid (out_valid),
    .out_num   (out_num),
    .err_out   (err_out),
    .busy      (busy)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act != exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    else n_pass++;
  endtask

  // Issue one command and wait for its out_valid pulse; lat counts cycles after accept
  task automatic do_cmd(input logic [1:0] o, input int n,
                        output longint res, output bit err, output int lat);
    int w = 0;
    res = -1; err = 1'b0; lat = -1;
    @(negedge clk);
    while (!in_ready && w < 40) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      chk("ready_wait", 0, 1);
      return;
    end
    op = o; in_num = n[IN_W-1:0]; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    repeat (40) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
    end
    if (!out_valid) begin
      chk("valid_wait", 0, 1);
      lat = -1;
      return;
    end
    res = out_num;
    err = err_out;
  endtask

  // Reference behaviour computed directly from the command rules
  task automatic model_cmd(input logic [1:0] o, input longint n,
                           output longint res, output bit err, output int lat);
    longint s, p;
    lat = 1;
    case (o)
      OP_STORE, OP_SHOW: begin
        s = m_total + m_temp;
        if (s > 99999) begin
          m_ovf = 1'b1;
          res = m_total;
        end else begin
          m_total = s;
          res = s;
          if (o == OP_SHOW) m_temp = 0;
        end
        if (o == OP_STORE) m_temp = n;
      end
      OP_UPDATE: begin
        if (n > 99) begin
          m_ovf = 1'b1;
          res = m_temp;
        end else begin
          lat = IN_W + 1;
          p = n * m_temp;
          if (p > 99999) begin
            m_ovf = 1'b1;
            res = m_temp;
          end else begin
            m_temp = p;
            res = p;
          end
        end
      end
      default: begin
        m_total = 0; m_temp = 0; m_ovf = 1'b0; res = 0;
      end
    endcase
    err = m_ovf;
  endtask

  initial begin
    longint res, eres;
    bit     err, eerr;
    int     lat, elat;
    bit     seen;
    logic [1:0] o;
    int     n;

    vecs.push_back('{OP_STORE,  1250,  0,     0, 1});
    vecs.push_back('{OP_SHOW,   0,     1250,  0, 1});
    vecs.push_back('{OP_STORE,  1000,  1250,  0, 1});
    vecs.push_back('{OP_UPDATE, 2,     2000,  0, 15});
    vecs.push_back('{OP_STORE,  100,   3250,  0, 1});
    vecs.push_back('{OP_SHOW,   0,     3350,  0, 1});
    vecs.push_back('{OP_STORE,  1000,  3350,  0, 1});
    vecs.push_back('{OP_UPDATE, 100,   1000,  1, 1});
    vecs.push_back('{OP_CLEAR,  0,     0,     0, 1});
    vecs.push_back('{OP_STORE,  1011,  0,     0, 1});
    vecs.push_back('{OP_UPDATE, 99,    1011,  1, 15});
    vecs.push_back('{OP_SHOW,   0,     1011,  1, 1});
    vecs.push_back('{OP_CLEAR,  0,     0,     0, 1});
    vecs.push_back('{OP_UPDATE, 0,     0,     0, 15});
    vecs.push_back('{OP_STORE,  99,    0,     0, 1});
    vecs.push_back('{OP_UPDATE, 0,     0,     0, 15});
    vecs.push_back('{OP_STORE,  9900,  0,     0, 1});
    vecs.push_back('{OP_UPDATE, 10,    99000, 0, 15});
    vecs.push_back('{OP_SHOW,   0,     99000, 0, 1});
    vecs.push_back('{OP_STORE,  1000,  99000, 0, 1});
    vecs.push_back('{OP_SHOW,   0,     99000, 1, 1});
    vecs.push_back('{OP_CLEAR,  0,     0,     0, 1});
    vecs.push_back('{OP_STORE,  1010,  0,     0, 1});
    vecs.push_back('{OP_UPDATE, 99,    99990, 0, 15});
    vecs.push_back('{OP_STORE,  9,     99990, 0, 1});
    vecs.push_back('{OP_SHOW,   0,     99999, 0, 1});

    // Reset state
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_num", out_num, 0);
    chk("rst_err_out", err_out, 0);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", in_ready, 1);

    foreach (vecs[i]) begin
      do_cmd(vecs[i].op, vecs[i].num, res, err, lat);
      chk($sformatf("vec%0d_res", i), res, vecs[i].res);
      chk($sformatf("vec%0d_err", i), err, vecs[i].err);
      chk($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
    end

    // Reset in the middle of a multiplication
    do_cmd(OP_CLEAR, 0, res, err, lat);
    do_cmd(OP_STORE, 50, res, err, lat);
    do_cmd(OP_SHOW, 0, res, err, lat);
    chk("pre_abort_total", res, 50);
    do_cmd(OP_STORE, 40, res, err, lat);
    @(negedge clk);
    op = OP_UPDATE; in_num = 3; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("abort_busy", busy, 1);
    reset = 1'b0;
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      seen |= out_valid;
    end
    reset = 1'b1;
    @(negedge clk);
    chk("abort_in_ready", in_ready, 1);
    repeat (20) begin
      @(negedge clk);
      seen |= out_valid;
    end
    chk("abort_no_pulse", seen, 0);
    chk("abort_out_num", out_num, 0);
    chk("abort_busy_low", busy, 0);
    chk("abort_err_out", err_out, 0);
    do_cmd(OP_SHOW, 0, res, err, lat);
    chk("abort_state_zero", res, 0);

    // in_valid held high across a multiplication
    do_cmd(OP_STORE, 7, res, err, lat);
    @(negedge clk);
    op = OP_UPDATE; in_num = 3; in_valid = 1'b1;
    @(posedge clk);
    #1 op = OP_SHOW; in_num = 0;
    lat = 0;
    repeat (40) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
    end
    chk("hold_mul_lat", lat, 15);
    chk("hold_mul_res", out_num, 21);
    @(negedge clk);
    chk("hold_ready_back", in_ready, 1);
    chk("hold_no_extra", out_valid, 0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("hold_show_valid", out_valid, 1);
    chk("hold_show_res", out_num, 21);

    // err_in is passed through combinationally and not latched
    @(negedge clk);
    err_in = 1'b1;
    #1 chk("err_in_high", err_out, 1);
    err_in = 1'b0;
    #1 chk("err_in_low", err_out, 0);
    chk("err_in_no_pulse", out_valid, 0);

    // Random commands against the model
    do_cmd(OP_CLEAR, 0, res, err, lat);
    m_total = 0; m_temp = 0; m_ovf = 1'b0;
    for (int k = 0; k < 150; k++) begin
      n = $urandom_range(0, 9);
      o = (n < 3) ? OP_STORE : (n < 5) ? OP_SHOW : (n < 9) ? OP_UPDATE : OP_CLEAR;
      if ($urandom_range(0, 1) == 0) n = $urandom_range(0, 110);
      else n = $urandom_range(0, 16383);
      model_cmd(o, n, eres, eerr, elat);
      do_cmd(o, n, res, err, lat);
      chk($sformatf("rnd%0d_op%0d_res", k, o), res, eres);
      chk($sformatf("rnd%0d_op%0d_err", k, o), err, eerr);
      chk($sformatf("rnd%0d_op%0d_lat", k, o), lat, elat);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/calc_exec_unit.md
# calc_exec_unit

Clocked, parametrised successor to the calculator execution stage. It accepts opcode/operand commands over a valid/ready handshake and keeps a running `total` and a pending operand `temp`. Multiplication runs as a multi-cycle shift-add, and overflow is checked against a decimal display limit. It sits between the keypad/BCD decoder, which supplies `in_num` and `err_in`, and the display driver, which consumes `out_num` and `err_out`.

## Interface
- `IN_W`, 14: operand width.
- `ACC_W`, 17: accumulator, `temp` and `out_num` width.
- `MAX_VAL`, 99999: largest legal result (display limit).
- `MUL_MAX_IN`, 99: largest legal multiplier operand.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-low; sampled on `clk` rising edge.
- `in_valid`  in  1  command present.
- `in_ready`  out  1  unit can accept a command.
- `op`  in  2  command: 0 STORE, 1 SHOW, 2 UPDATE, 3 CLEAR.
- `in_num`  in  IN_W  operand (unsigned).
- `err_in`  in  1  upstream error (e.g. invalid digit).
- `out_valid`  out  1  one-cycle pulse; `out_num` updated this cycle.
- `out_num`  out  ACC_W  result; held between pulses.
- `err_out`  out  1  `err_in | overflow`, combinational.
- `busy`  out  1  multiplication in progress.

## Operation
- Accept a command when `in_valid && in_ready`. `op` and `in_num` are captured that cycle.
- STORE: `total <= total + temp`; `temp <= in_num`; result = new `total`.
- SHOW: `total <= total + temp`; `temp <= 0`; result = new `total`.
- UPDATE:
  - If `in_num > MUL_MAX_IN`: set `overflow`; `temp` is unchanged; result = `temp`.
  - Otherwise compute the full product `in_num * temp` (IN_W+ACC_W bits).
  - If the product > `MAX_VAL`: set `overflow`.
  - Else `temp <= product`; result = product.
- CLEAR: `total`, `temp`, `overflow` and `out_num` go to 0; result = 0.
- Addition overflow: if `total + temp > MAX_VAL` (computed at ACC_W+1 bits), set `overflow`, leave `total` and `temp` unchanged, and result = old `total`. For STORE, `temp` still loads `in_num`.
- `overflow` is sticky; only CLEAR or reset clears it. Commands still execute while it is set.
- FSM states:
  - IDLE: `in_ready` = 1. UPDATE with a legal `in_num` goes to MUL. Any other command goes to DONE.
  - MUL: shift-add, one multiplier bit per cycle, exactly IN_W cycles, then DONE.
  - DONE: pulse `out_valid`, then return to IDLE.
- `busy` = 1 exactly in MUL.

## Timing
- Reset values: `out_num` 0, `out_valid` 0, `busy` 0; `total`, `temp` and `overflow` 0; state IDLE.
- `in_ready` is 0 while `reset` is low and 1 on the first cycle after release.
- STORE, SHOW, CLEAR and rejected UPDATE: accepted at edge N, `out_valid` high in cycle N+1.
- Legal UPDATE: accepted at edge N, `out_valid` high in cycle N+IN_W+1 (15 cycles at default).
- `in_ready` is low from accept until the cycle after `out_valid`, so back-to-back commands have one command per 2 cycles minimum.
- `reset` low mid-MUL aborts the multiplication: no `out_valid` pulse, and all state returns to reset values.
- `err_in` is never latched; `err_out` follows it combinationally.
- `temp == 0` or `in_num == 0` in UPDATE still takes the full IN_W cycles. The result is 0 with no overflow.

## Configuration
- `CALC_SATURATE_EN` defined: any overflow (add or multiply, including `in_num > MUL_MAX_IN`) clamps the affected register to `MAX_VAL`, reports `MAX_VAL` as the result, and sets `overflow`.
- Undefined: the overflowing operation is dropped as described in Operation; only `overflow` is set.

## Structure
- `calc_pkg` holds:
  - the `op` enum (STORE/SHOW/UPDATE/CLEAR);
  - the FSM state enum (IDLE/MUL/DONE);
  - default constants for `MAX_VAL` and `MUL_MAX_IN`.
- Sub-module `calc_seq_mul` is the IN_W-cycle shift-add multiplier, with start/done and full-width product output. The top module holds the FSM, registers and overflow compare.

## Test plan
- Sequence STORE 1250, SHOW, STORE 1000, UPDATE 2, STORE 100, SHOW -> `out_num` pulses 0, 1250, 1250, 2000, 3250, 3350. UPDATE result arrives 15 cycles after accept; `err_out` stays 0 throughout.
- `temp`=1000, UPDATE 100 -> `overflow` set after 1 cycle, `temp` stays 1000, `err_out`=1. A following CLEAR -> `out_num` 0, `err_out` 0.
- `temp`=1011, UPDATE 99 (product 100089) -> `overflow` set. Without the macro `temp` stays 1011; with `CALC_SATURATE_EN` `temp` and `out_num` are 99999.
- `total`=99000, `temp`=1000, SHOW -> sum 100000 -> `overflow` set, `total` stays 99000 without the macro, or is 99999 with it.
- `reset` low 5 cycles into a legal UPDATE -> no `out_valid` pulse, all outputs 0. `in_ready` is 1 one cycle after release.
- `in_valid` held high during MUL -> not accepted until `in_ready` returns. `err_in` pulse -> `err_out` follows it in the same cycle with no state change.
